// File: rtl/servo_cmd_scheduler.sv
// servo_cmd_scheduler
//   Parses the UART command stream (0xA5, CMD, payload, CHK), stages PWM duty
//   and enable changes per axis, and answers each packet with ACK 0x5A or
//   NAK 0xEE. Duty changes are double-buffered: the shadow moves to the live
//   registers only on that axis's period_sync, so phases never tear.
//   DISABLE bypasses the sync and drops pwm_en immediately.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready   byte input, consumed on rx_valid & rx_ready
//   tx_data/tx_valid/tx_ready   response byte, held until tx_ready
//   period_sync[NUM_AXES]    one-cycle pulse at each axis PWM period start
//   duty_out                 live duties, axis n phase p at [(3n+p)*DUTY_W +: DUTY_W]
//   pwm_en[NUM_AXES]         live per-axis enable
//   err_cnt                  saturating count of rejected packets
//   fsm_state                debug view of the parser state (HUNT=0 .. RESP=5)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid, once raised, holds its data stable until that edge.
module servo_cmd_scheduler #(
  parameter int NUM_AXES    = 3,
  parameter int DUTY_W      = 16,
  parameter int DUTY_MAX    = 2499,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  input  logic [NUM_AXES-1:0]          period_sync,
  output logic [NUM_AXES*3*DUTY_W-1:0] duty_out,
  output logic [NUM_AXES-1:0]          pwm_en,
  output logic [7:0]                   err_cnt,
  output logic [2:0]                   fsm_state
);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_CMD     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_EXEC    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam logic [3:0]        OP_SET     = 4'h1;
  localparam logic [3:0]        OP_EN      = 4'h2;
  localparam logic [3:0]        OP_DIS     = 4'h3;
  localparam int                GAP_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]       DUTY_MAX16 = 16'(DUTY_MAX);

  state_t             state;
  logic [7:0]         cmd;
  logic               err;
  logic [7:0]         xor_acc;
  logic [2:0]         pay_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [7:0]         stage [0:5];
  logic               take;
  logic               cmd_bad;
  logic               exec_ok;

  logic [DUTY_W-1:0]  shadow [NUM_AXES][3];
  logic [DUTY_W-1:0]  live   [NUM_AXES][3];
  logic [NUM_AXES-1:0] pending;
  logic [NUM_AXES-1:0] en_pending;

  assign take      = rx_valid & rx_ready;
  assign fsm_state = state;
  // Unknown opcodes and out-of-range axes are remembered and NAKed at EXEC.
  assign cmd_bad   = !(rx_data[7:4] inside {OP_SET, OP_EN, OP_DIS}) ||
                     (int'(rx_data[1:0]) >= NUM_AXES);
  assign exec_ok   = (state == S_EXEC) && !err;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [15:0] raw);
    return (raw > DUTY_MAX16) ? DUTY_W'(DUTY_MAX16) : DUTY_W'(raw);
  endfunction

  // Packet parser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_HUNT;
      cmd      <= '0;
      err      <= 1'b0;
      xor_acc  <= '0;
      pay_cnt  <= '0;
      gap_cnt  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      rx_ready <= 1'b1;
      err_cnt  <= '0;
      for (int i = 0; i < 6; i++) stage[i] <= '0;
    end else begin
      case (state)
        S_HUNT: begin
          gap_cnt <= '0;
          if (take && rx_data == 8'hA5) state <= S_CMD;
        end
        S_CMD, S_PAYLOAD, S_CHK: begin
          if (take) begin
            gap_cnt <= '0;
            case (state)
              S_CMD: begin
                cmd     <= rx_data;
                xor_acc <= rx_data;
                err     <= cmd_bad;
                pay_cnt <= '0;
                state   <= (rx_data[7:4] == OP_SET) ? S_PAYLOAD : S_CHK;
              end
              S_PAYLOAD: begin
                stage[pay_cnt] <= rx_data;
                xor_acc        <= xor_acc ^ rx_data;
                if (pay_cnt == 3'd5) state <= S_CHK;
                else                 pay_cnt <= pay_cnt + 3'd1;
              end
              default: begin
                err      <= err | (rx_data != xor_acc);
                rx_ready <= 1'b0;
                state    <= S_EXEC;
              end
            endcase
          end else if (gap_cnt == GAP_LAST) begin
            // Inter-byte gap expired: abandon the packet and NAK it.
            err      <= 1'b1;
            rx_ready <= 1'b0;
            state    <= S_EXEC;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          tx_valid <= 1'b1;
          tx_data  <= err ? 8'hEE : 8'h5A;
          if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            state    <= S_HUNT;
          end
        end
        default: begin
          state    <= S_HUNT;
          rx_ready <= 1'b1;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

  // Shadow / live registers. Statement order sets priority: a write in EXEC
  // lands after the sync transfer, so a same-cycle sync moves the old shadow
  // and pending stays set for the new one. DISABLE wins over everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      en_pending <= '0;
      pwm_en     <= '0;
      for (int n = 0; n < NUM_AXES; n++) begin
        for (int p = 0; p < 3; p++) begin
          shadow[n][p] <= '0;
          live[n][p]   <= '0;
        end
      end
    end else begin
      for (int n = 0; n < NUM_AXES; n++) begin
        if (period_sync[n] && pending[n]) begin
          for (int p = 0; p < 3; p++) live[n][p] <= shadow[n][p];
          pending[n] <= 1'b0;
        end
        if (period_sync[n] && en_pending[n]) begin
          pwm_en[n]     <= 1'b1;
          en_pending[n] <= 1'b0;
        end
        if (exec_ok && int'(cmd[1:0]) == n) begin
          if (cmd[7:4] == OP_SET) begin
            for (int p = 0; p < 3; p++)
              shadow[n][p] <= clamp_duty({stage[2*p+1], stage[2*p]});
            pending[n] <= 1'b1;
          end
          if (cmd[7:4] == OP_EN) en_pending[n] <= 1'b1;
          if (cmd[7:4] == OP_DIS) begin
            pwm_en[n]     <= 1'b0;
            en_pending[n] <= 1'b0;
          end
        end
      end
    end
  end

  for (genvar gn = 0; gn < NUM_AXES; gn++) begin : g_axis
    for (genvar gp = 0; gp < 3; gp++) begin : g_phase
      assign duty_out[(3*gn+gp)*DUTY_W +: DUTY_W] = live[gn][gp];
    end
  end

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Directed bench for servo_cmd_scheduler. Response bytes are checked by a
// scoreboard monitor against exp_q; register state is checked inline.
module tb_servo_cmd_scheduler;

  localparam int NUM_AXES = 3;
  localparam int DUTY_W   = 16;

  logic                         clk;
  logic                         reset_n;
  logic [7:0]                   rx_data;
  logic                         rx_valid;
  logic                         rx_ready;
  logic [7:0]                   tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic [NUM_AXES-1:0]          period_sync;
  logic [NUM_AXES*3*DUTY_W-1:0] duty_out;
  logic [NUM_AXES-1:0]          pwm_en;
  logic [7:0]                   err_cnt;
  logic [2:0]                   fsm_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];

  servo_cmd_scheduler #(
    .NUM_AXES(NUM_AXES), .DUTY_W(DUTY_W), .DUTY_MAX(2499), .TIMEOUT_CYC(50000)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .period_sync(period_sync), .duty_out(duty_out), .pwm_en(pwm_en),
    .err_cnt(err_cnt), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] duty(input int a, input int p);
    return duty_out[(3*a+p)*DUTY_W +: DUTY_W];
  endfunction

  task automatic check_axis(input string name, input int a, input logic [15:0] da,
                            input logic [15:0] db, input logic [15:0] dc);
    check({name, "_a"}, 32'(duty(a, 0)), 32'(da));
    check({name, "_b"}, 32'(duty(a, 1)), 32'(db));
    check({name, "_c"}, 32'(duty(a, 2)), 32'(dc));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_unexpected: got 0x%0h expected no response at %0t", tx_data, $time);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks (time kept at posedge + 1) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 200) begin
      tick(1);
      k++;
    end
    tick(1);
    rx_valid = 1'b0;
    if (k >= 200) check("rx_ready_timeout", 32'(k), 32'(0));
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  task automatic wait_resp(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      tick(1);
      k++;
    end
    check("resp_outstanding", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  task automatic sync(input logic [NUM_AXES-1:0] m);
    period_sync = m;
    tick(1);
    period_sync = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n     = 1'b0;
    rx_data     = '0;
    rx_valid    = 1'b0;
    tx_ready    = 1'b1;
    period_sync = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Reset state
    check("rst_duty", 32'(duty_out == '0), 32'(1));
    check("rst_pwm_en", 32'(pwm_en), 32'(0));
    check("rst_err_cnt", 32'(err_cnt), 32'(0));
    check("rst_tx_valid", 32'(tx_valid), 32'(0));
    check("rst_tx_data", 32'(tx_data), 32'(0));
    check("rst_rx_ready", 32'(rx_ready), 32'(1));
    check("rst_state", 32'(fsm_state), 32'(0));

    // ENABLE axis 1: enable waits for period_sync[1]
    exp_q.push_back(8'h5A);
    pkt = '{8'hA5, 8'h21, 8'h21};
    send_pkt();
    wait_resp(50);
    tick(100);
    check("en_before_sync", 32'(pwm_en), 32'(3'b000));
    sync(3'b010);
    check("en_after_sync", 32'(pwm_en), 32'(3'b010));

    // SET_DUTY axis 0 with bad checksum (good CHK is 0x03)
    exp_q.push_back(8'hEE);
    pkt = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h10, 8'h02};
    send_pkt();
    wait_resp(50);
    check("badchk_err_cnt", 32'(err_cnt), 32'(1));
    sync(3'b001);
    check_axis("badchk_live", 0, 16'd0, 16'd0, 16'd0);

    // SET_DUTY axis 0, C clamps to 2499
    exp_q.push_back(8'h5A);
    pkt = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h10, 8'h03};
    send_pkt();
    wait_resp(50);
    tick(5);
    check_axis("set0_pre_sync", 0, 16'd0, 16'd0, 16'd0);
    sync(3'b001);
    check_axis("set0_post_sync", 0, 16'd256, 16'd512, 16'd2499);
    check("set0_pwm_en", 32'(pwm_en), 32'(3'b010));

    // Timeout mid-packet
    exp_q.push_back(8'hEE);
    pkt = '{8'hA5, 8'h10, 8'h00, 8'h01};
    send_pkt();
    check("to_mid_state", 32'(fsm_state), 32'(2));
    wait_resp(50100);
    check("to_err_cnt", 32'(err_cnt), 32'(2));
    check("to_state_hunt", 32'(fsm_state), 32'(0));
    exp_q.push_back(8'h5A);
    pkt = '{8'hA5, 8'h20, 8'h20};
    send_pkt();
    wait_resp(50);

    // DISABLE axis 1 takes effect at the EXEC edge, no sync needed
    exp_q.push_back(8'h5A);
    pkt = '{8'hA5, 8'h31, 8'h31};
    send_pkt();
    check("dis_before_exec", 32'(pwm_en), 32'(3'b010));
    tick(1);
    check("dis_at_exec", 32'(pwm_en), 32'(3'b000));
    wait_resp(50);

    // Axis 3 and an unknown opcode are rejected
    exp_q.push_back(8'hEE);
    pkt = '{8'hA5, 8'h23, 8'h23};
    send_pkt();
    wait_resp(50);
    check("axis3_err_cnt", 32'(err_cnt), 32'(3));
    exp_q.push_back(8'hEE);
    pkt = '{8'hA5, 8'h50, 8'h50};
    send_pkt();
    wait_resp(50);
    check("badop_err_cnt", 32'(err_cnt), 32'(4));

    // Axis 2: shadow 10/10/10 live, then SET 20s with sync in its EXEC cycle
    exp_q.push_back(8'h5A);
    pkt = '{8'hA5, 8'h12, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'h18};
    send_pkt();
    wait_resp(50);
    sync(3'b100);
    check_axis("ax2_first", 2, 16'd10, 16'd10, 16'd10);

    exp_q.push_back(8'h5A);
    tx_ready = 1'b0;
    pkt = '{8'hA5, 8'h12, 8'h14, 8'h00, 8'h14, 8'h00, 8'h14, 8'h00, 8'h06};
    send_pkt();
    check("ax2_in_exec", 32'(fsm_state), 32'(4));
    sync(3'b100);
    check_axis("ax2_same_cycle", 2, 16'd10, 16'd10, 16'd10);
    for (int i = 0; i < 20; i++) begin
      check("hold_rx_ready", 32'(rx_ready), 32'(0));
      check("hold_tx_valid", 32'(tx_valid), 32'(1));
      tick(1);
    end
    tx_ready = 1'b1;
    wait_resp(50);
    sync(3'b100);
    check_axis("ax2_next_sync", 2, 16'd20, 16'd20, 16'd20);
    check_axis("ax0_untouched", 0, 16'd256, 16'd512, 16'd2499);

    // Reset mid-packet: no response, everything cleared
    pkt = '{8'hA5, 8'h12, 8'h01};
    send_pkt();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(20);
    check("rst2_state", 32'(fsm_state), 32'(0));
    check("rst2_duty", 32'(duty_out == '0), 32'(1));
    check("rst2_err_cnt", 32'(err_cnt), 32'(0));
    check("rst2_tx_valid", 32'(tx_valid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
